// File: rtl/rty_pkg.sv
// Shared types and helpers for the retry credit scheduler.
package rty_pkg;
  localparam int QOS_CLS_W      = 2;
  localparam int CREDIT_MAX_DEF = 16;
  localparam int CREDIT_W       = $clog2(CREDIT_MAX_DEF + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Class is the top two bits of the 4-bit qos_type.
  function automatic logic [QOS_CLS_W-1:0] qos2cls(input logic [3:0] qos);
    return QOS_CLS_W'(qos >> 2);
  endfunction
endpackage

// File: rtl/rty_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module rty_rr_pick
  import rty_pkg::*;
#(
  parameter int SRC_NODE_W = 2
) (
  input  logic [(1<<SRC_NODE_W)-1:0] req,
  input  logic [SRC_NODE_W-1:0]      ptr,
  output logic [(1<<SRC_NODE_W)-1:0] pick_oh,
  output logic [SRC_NODE_W-1:0]      pick_idx
);
  localparam int NUM_SRC = 1 << SRC_NODE_W;

  logic [SRC_NODE_W-1:0] idx_scan;
  logic                  found;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    idx_scan = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx_scan = ptr + SRC_NODE_W'(i);
      if (!found && req[idx_scan]) begin
        found             = 1'b1;
        pick_idx          = idx_scan;
        pick_oh[idx_scan] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rty_credit_scheduler.sv
// Retry grant scheduler: per-(source,class) pending counters, a credit pool, strict class
// priority with round-robin sources inside a class and a starvation override.
module rty_credit_scheduler
  import rty_pkg::*;
#(
  parameter int SRC_NODE_W = 2,
  parameter int QoS_CLASS  = 4,
  parameter int CNT_W      = 5,
  parameter int CREDIT_MAX = 16,
  parameter int STARVE_TH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_rty_rec,
  output logic                  rdy_rty_rec,
  input  logic [SRC_NODE_W-1:0] rty_src_id,
  input  logic [3:0]            rty_qos,
  input  logic                  vld_credit_ret,
  output logic                  vld_out_grant,
  input  logic                  rdy_out_grant,
  output logic [SRC_NODE_W-1:0] grant_src,
  output logic [QOS_CLS_W-1:0]  grant_cls,
  output logic [CREDIT_W-1:0]   credit_cnt,
  output logic                  err_credit_ovf
);
  localparam int NUM_SRC = 1 << SRC_NODE_W;
  localparam int NUM_CLS = QoS_CLASS;
  localparam int STV_W   = $clog2(STARVE_TH + 1);

  logic [CNT_W-1:0]      pend_reg  [NUM_SRC][NUM_CLS];
  logic [CNT_W-1:0]      pend_next [NUM_SRC][NUM_CLS];
  logic [SRC_NODE_W-1:0] pick_idx  [NUM_CLS];
  logic [NUM_CLS-1:0]    cls_any;
  logic [NUM_CLS-1:0]    starve_hit;
  logic [QOS_CLS_W-1:0]  rec_cls;
  logic [QOS_CLS_W-1:0]  sel_cls;
  logic [CREDIT_W-1:0]   credit_next;
  logic                  ovf_next;
  logic                  rec_fire;
  logic                  grant_fire;
  logic                  launch;
  state_t                state_reg;
  state_t                state_next;

  assign rec_cls     = qos2cls(rty_qos);
  // Readiness looks only at the stored count, so a same-cycle grant never frees a slot.
  assign rdy_rty_rec = (pend_reg[rty_src_id][rec_cls] != '1);
  assign rec_fire    = vld_rty_rec && rdy_rty_rec;
  assign grant_fire  = vld_out_grant && rdy_out_grant;
  assign launch      = (state_reg == IDLE) && (state_next == GRANT);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLS; gi++) begin : g_cls
      logic [NUM_SRC-1:0]    req;
      logic [NUM_SRC-1:0]    pick_oh;
      logic [SRC_NODE_W-1:0] rr_ptr_reg;
      logic [STV_W-1:0]      starve_reg;
      logic                  cls_granted;

      always_comb begin
        req = '0;
        for (int s = 0; s < NUM_SRC; s++) req[s] = (pend_reg[s][gi] != '0);
      end

      rty_rr_pick #(.SRC_NODE_W(SRC_NODE_W)) u_pick (
        .req      (req),
        .ptr      (rr_ptr_reg),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx[gi])
      );

      assign cls_any[gi]    = |pick_oh;
      assign cls_granted    = grant_fire && (grant_cls == QOS_CLS_W'(gi));
      assign starve_hit[gi] = cls_any[gi] && (starve_reg >= STV_W'(STARVE_TH));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           rr_ptr_reg <= '0;
        else if (cls_granted) rr_ptr_reg <= grant_src + 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              starve_reg <= '0;
        else if (cls_granted || !cls_any[gi])    starve_reg <= '0;
        else if (grant_fire && starve_reg < STV_W'(STARVE_TH)) starve_reg <= starve_reg + 1'b1;
      end
    end
  endgenerate

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int c = 0; c < NUM_CLS; c++) begin
        pend_next[s][c] = pend_reg[s][c];
        if (rec_fire && rty_src_id == SRC_NODE_W'(s) && rec_cls == QOS_CLS_W'(c) &&
            !(grant_fire && grant_src == SRC_NODE_W'(s) && grant_cls == QOS_CLS_W'(c)))
          pend_next[s][c] = pend_reg[s][c] + 1'b1;
        else if (grant_fire && grant_src == SRC_NODE_W'(s) && grant_cls == QOS_CLS_W'(c) &&
                 !(rec_fire && rty_src_id == SRC_NODE_W'(s) && rec_cls == QOS_CLS_W'(c)))
          pend_next[s][c] = pend_reg[s][c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SRC; s++)
        for (int c = 0; c < NUM_CLS; c++) pend_reg[s][c] <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++)
        for (int c = 0; c < NUM_CLS; c++) pend_reg[s][c] <= pend_next[s][c];
    end
  end

  always_comb begin
    credit_next = credit_cnt;
    ovf_next    = err_credit_ovf;
    if (vld_credit_ret && !grant_fire) begin
      if (credit_cnt == CREDIT_W'(CREDIT_MAX)) ovf_next = 1'b1;
      else credit_next = credit_cnt + 1'b1;
    end else if (grant_fire && !vld_credit_ret) begin
      credit_next = credit_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt     <= CREDIT_W'(CREDIT_MAX);
      err_credit_ovf <= 1'b0;
    end else begin
      credit_cnt     <= credit_next;
      err_credit_ovf <= ovf_next;
    end
  end

  // Starved classes override priority, lowest starved class first.
  always_comb begin
    sel_cls = '0;
    for (int c = 0; c < NUM_CLS; c++)
      if (cls_any[c]) sel_cls = QOS_CLS_W'(c);
    for (int c = NUM_CLS - 1; c >= 0; c--)
      if (starve_hit[c]) sel_cls = QOS_CLS_W'(c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if ((|cls_any) && credit_cnt != '0) state_next = GRANT;
      GRANT:   if (rdy_out_grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    vld_out_grant = (state_reg == GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_src <= '0;
      grant_cls <= '0;
    end else if (launch) begin
      grant_src <= pick_idx[sel_cls];
      grant_cls <= sel_cls;
    end
  end
endmodule

// File: tb/tb_rty_credit_scheduler.sv
// Scoreboard bench for rty_credit_scheduler: a count/queue reference model predicts
// grants and per-cycle status; a negedge monitor compares the DUT against it.
module tb_rty_credit_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       vld_rty_rec = 1'b0;
  logic       vld_credit_ret = 1'b0;
  logic       rdy_out_grant = 1'b0;
  logic [1:0] rty_src_id = '0;
  logic [3:0] rty_qos = '0;
  logic       rdy_rty_rec, vld_out_grant, err_credit_ovf;
  logic [1:0] grant_src, grant_cls;
  logic [4:0] credit_cnt;

  int errors = 0;
  int checks = 0;

  int m_pend [4][4];
  int m_credit;
  int m_rr [4];
  int m_starve [4];
  bit m_vld, m_err;
  int m_gsrc, m_gcls;

  bit snap_vld, snap_err, snap_rdy;
  int snap_credit;
  int exp_q[$];
  int hist[$];

  always #5 clk = ~clk;

  rty_credit_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vld_rty_rec    (vld_rty_rec),
    .rdy_rty_rec    (rdy_rty_rec),
    .rty_src_id     (rty_src_id),
    .rty_qos        (rty_qos),
    .vld_credit_ret (vld_credit_ret),
    .vld_out_grant  (vld_out_grant),
    .rdy_out_grant  (rdy_out_grant),
    .grant_src      (grant_src),
    .grant_cls      (grant_cls),
    .credit_cnt     (credit_cnt),
    .err_credit_ovf (err_credit_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cls_pend(input int c);
    int sum = 0;
    for (int s = 0; s < 4; s++) sum += m_pend[s][c];
    return sum;
  endfunction

  function automatic int hget(input int i);
    if (i < hist.size()) return hist[i];
    return 99;
  endfunction

  // Reference selection: starved classes (lowest first), else highest pending class;
  // inside the class, the first pending source from the round-robin pointer onward.
  function automatic void pick(output int s, output int c);
    c = -1;
    for (int k = 0; k < 4; k++)
      if (c < 0 && m_starve[k] >= 8 && cls_pend(k) > 0) c = k;
    for (int k = 3; k >= 0; k--)
      if (c < 0 && cls_pend(k) > 0) c = k;
    s = -1;
    for (int k = 0; k < 4; k++)
      if (s < 0 && m_pend[(m_rr[c] + k) % 4][c] > 0) s = (m_rr[c] + k) % 4;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 4; c++) m_pend[s][c] = 0;
    for (int c = 0; c < 4; c++) begin
      m_rr[c] = 0;
      m_starve[c] = 0;
    end
    m_credit = 16; m_vld = 0; m_err = 0; m_gsrc = 0; m_gcls = 0;
    snap_vld = 0; snap_err = 0; snap_rdy = 1; snap_credit = 16;
    exp_q.delete();
  endfunction

  // One clock of stimulus; the model advances to the state the DUT holds after the next edge.
  task automatic drive_cycle(input bit rv, input int src, input int qos, input bit cret, input bit rdy);
    int  cls, ss, sc;
    bit  hs, sel, rec_ok, anyp;
    @(posedge clk); #1;
    cls = qos / 4;
    snap_vld = m_vld; snap_credit = m_credit; snap_err = m_err;
    snap_rdy = (m_pend[src][cls] != 31);
    vld_rty_rec = rv; rty_src_id = 2'(src); rty_qos = 4'(qos);
    vld_credit_ret = cret; rdy_out_grant = rdy;

    anyp = 0;
    for (int c = 0; c < 4; c++) if (cls_pend(c) > 0) anyp = 1;
    hs  = m_vld && rdy;
    sel = !m_vld && m_credit > 0 && anyp;
    ss = 0; sc = 0;
    if (sel) begin
      pick(ss, sc);
      exp_q.push_back(sc * 4 + ss);
    end
    rec_ok = rv && (m_pend[src][cls] != 31);
    for (int c = 0; c < 4; c++) begin
      if ((hs && m_gcls == c) || cls_pend(c) == 0) m_starve[c] = 0;
      else if (hs && m_starve[c] < 8) m_starve[c]++;
    end
    if (hs) begin
      m_pend[m_gsrc][m_gcls]--;
      m_rr[m_gcls] = (m_gsrc + 1) % 4;
    end
    if (rec_ok) m_pend[src][cls]++;
    if (cret && !hs) begin
      if (m_credit == 16) m_err = 1;
      else m_credit++;
    end else if (hs && !cret) m_credit--;
    if (hs) m_vld = 0;
    else if (sel) begin
      m_vld = 1; m_gsrc = ss; m_gcls = sc;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, rdy);
  endtask

  task automatic rand_cycles(input int n, input int prec, input int pret, input int prdy);
    for (int i = 0; i < n; i++)
      drive_cycle($urandom_range(99) < prec, $urandom_range(3), $urandom_range(15),
                  $urandom_range(99) < pret, $urandom_range(99) < prdy);
  endtask

  // Asserts reset between edges so its asynchronous effect is visible at once.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    vld_rty_rec = 0; vld_credit_ret = 0; rdy_out_grant = 0;
    model_reset();
    #1;
    chk("rst_vld", vld_out_grant, 0);
    chk("rst_credit", credit_cnt, 16);
    chk("rst_err", err_credit_ovf, 0);
    chk("rst_grant_src", grant_src, 0);
    chk("rst_grant_cls", grant_cls, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  always @(negedge clk) begin : monitor
    int e;
    chk("vld_out_grant", vld_out_grant, snap_vld);
    chk("credit_cnt", credit_cnt, snap_credit);
    chk("err_credit_ovf", err_credit_ovf, snap_err);
    if (vld_rty_rec) chk("rdy_rty_rec", rdy_rty_rec, snap_rdy);
    if (rst_n && vld_out_grant && rdy_out_grant) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_unexpected: got cls %0d src %0d expected none", grant_cls, grant_src);
      end else begin
        e = exp_q.pop_front();
        chk("grant_cls_src", {grant_cls, grant_src}, e);
      end
      hist.push_back({grant_cls, grant_src});
    end
  end

  initial begin
    model_reset();
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Single record, class 3 from source 1
    hist.delete();
    drive_cycle(1, 1, 12, 0, 1);
    idle(4, 1);
    chk("t1_count", hist.size(), 1);
    chk("t1_grant", hget(0), 13);
    chk("t1_credit", credit_cnt, 15);

    // Strict priority: cls3/src2 beats cls0/src0 queued behind a held grant
    do_reset();
    hist.delete();
    drive_cycle(1, 3, 4, 0, 0);
    idle(1, 0);
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 2, 12, 0, 0);
    idle(2, 0);
    idle(8, 1);
    chk("t2_first", hget(0), 7);
    chk("t2_second", hget(1), 14);
    chk("t2_third", hget(2), 0);

    // Round robin inside class 2
    do_reset();
    hist.delete();
    for (int i = 0; i < 6; i++) drive_cycle(1, i % 3, 8, 0, 1);
    idle(8, 1);
    for (int i = 0; i < 6; i++) chk("t3_rr_order", hget(i), 8 + (i % 3));

    // Starvation: class 0 forced after 8 class-3 grants
    do_reset();
    hist.delete();
    drive_cycle(1, 0, 12, 0, 1);
    drive_cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) drive_cycle(1, i % 4, 12 + (i % 4), 0, 1);
    idle(6, 1);
    for (int i = 0; i < 8; i++) chk("t4_cls3_before", hget(i) / 4, 3);
    chk("t4_ninth_cls0", hget(8) / 4, 0);
    chk("t4_tenth_cls3", hget(9) / 4, 3);

    // Credit exhaustion, single return, overflow
    do_reset();
    hist.delete();
    for (int i = 0; i < 20; i++) drive_cycle(1, $urandom_range(3), $urandom_range(15), 0, 1);
    idle(30, 1);
    chk("t5_credit_zero", credit_cnt, 0);
    chk("t5_vld_low", vld_out_grant, 0);
    chk("t5_grants", hist.size(), 16);
    drive_cycle(0, 0, 0, 1, 1);
    idle(8, 1);
    chk("t5_one_more", hist.size(), 17);
    chk("t5_credit_again", credit_cnt, 0);
    do_reset();
    drive_cycle(0, 0, 0, 1, 1);
    idle(1, 1);
    chk("t5_ovf", err_credit_ovf, 1);
    chk("t5_ovf_credit", credit_cnt, 16);

    // Held grant stays stable; reset mid-grant abandons it
    do_reset();
    hist.delete();
    drive_cycle(1, 2, 0, 0, 1);
    idle(4, 1);
    drive_cycle(1, 3, 4, 0, 0);
    idle(1, 0);
    drive_cycle(1, 0, 12, 0, 0);
    idle(4, 0);
    chk("t6_hold_vld", vld_out_grant, 1);
    chk("t6_hold_src", grant_src, 3);
    chk("t6_hold_cls", grant_cls, 1);
    chk("t6_credit_before", credit_cnt, 15);
    do_reset();

    // Randomized traffic mixes
    rand_cycles(400, 40, 30, 70);
    rand_cycles(300, 80, 5, 90);
    rand_cycles(200, 60, 60, 30);
    rand_cycles(100, 0, 20, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
